// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, PC step,
// buffer depth and FSM state encoding.
package fetch_unit_pkg;
  localparam int WORD   = 64;
  localparam int ILEN   = 32;
  localparam int PC_INC = 4;
  localparam int DEPTH  = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/fetch_unit_fifo.sv
// Two-entry instruction buffer holding {instruction, pc} pairs in fetch
// order, with flush taking priority over push and pop.
module fetch_fifo #(
  parameter int WORD = fetch_unit_pkg::WORD
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push_i,
  input  logic                            pop_i,
  input  logic                            flush_i,
  input  logic [fetch_unit_pkg::ILEN-1:0] push_instr_i,
  input  logic [WORD-1:0]                 push_pc_i,
  output logic [1:0]                      count_o,
  output logic                            head_valid_o,
  output logic [fetch_unit_pkg::ILEN-1:0] head_instr_o,
  output logic [WORD-1:0]                 head_pc_o
);
  import fetch_unit_pkg::*;

  logic [ILEN-1:0] instr_q [2];
  logic [WORD-1:0] pc_q    [2];
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            push_s, pop_s;

  assign push_s = push_i && (count_q != 2'd2);
  assign pop_s  = pop_i && (count_q != 2'd0);

  // Next-state pointers and occupancy; flush empties the buffer outright.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_s) wr_ptr_d = ~wr_ptr_q;
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = ~rd_ptr_q;
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
    end else if (push_s && !flush_i) begin
      instr_q[wr_ptr_q] <= push_instr_i;
      pc_q[wr_ptr_q]    <= push_pc_i;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != 2'd0);
  assign head_instr_o = instr_q[rd_ptr_q];
  assign head_pc_o    = pc_q[rd_ptr_q];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, single outstanding-slot
// request tracking, branch redirect and the decode-facing buffer.
module fetch_unit #(
  parameter int              WORD     = fetch_unit_pkg::WORD,
  parameter logic [WORD-1:0] START_PC = '0,
  parameter int              DEPTH    = fetch_unit_pkg::DEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            fetch_en,
  input  logic                            br_taken,
  input  logic [WORD-1:0]                 br_target,
  output logic                            imem_req,
  output logic [WORD-1:0]                 imem_addr,
  input  logic [fetch_unit_pkg::ILEN-1:0] imem_rdata,
  output logic                            if_valid,
  output logic [fetch_unit_pkg::ILEN-1:0] if_instr,
  output logic [WORD-1:0]                 if_pc,
  input  logic                            if_ready
);
  import fetch_unit_pkg::*;

  state_e          state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic [WORD-1:0] tag_q, tag_d;
  logic            inflight_q, inflight_d;
  logic [1:0]      count_s;
  logic [1:0]      occ_s;
  logic            req_s, push_s, pop_s;

  assign occ_s = count_s + {1'b0, inflight_q};

  // FSM next state and request issue; issue follows the state being entered
  // so fetch_en takes effect in the same cycle, and reset blocks it at once.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = fetch_en ? ST_RUN : ST_IDLE;
      ST_RUN:  state_d = fetch_en ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    req_s = reset && (state_d == ST_RUN) && !br_taken && (int'(occ_s) < DEPTH);
  end

  // PC, tag and in-flight tracking; a redirect overrides everything else.
  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = req_s;
    if (br_taken) begin
      pc_d = br_target & {{(WORD-2){1'b1}}, 2'b00};
    end else if (req_s) begin
      pc_d  = pc_q + WORD'(PC_INC);
      tag_d = pc_q;
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= START_PC;
      tag_q      <= START_PC;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  assign push_s    = inflight_q && !br_taken;
  assign pop_s     = if_valid && if_ready;
  assign imem_req  = req_s;
  assign imem_addr = pc_q;

  fetch_fifo #(.WORD(WORD)) u_fifo (
    .clk          (clk),
    .rst_n        (reset),
    .push_i       (push_s),
    .pop_i        (pop_s),
    .flush_i      (br_taken),
    .push_instr_i (imem_rdata),
    .push_pc_i    (tag_q),
    .count_o      (count_s),
    .head_valid_o (if_valid),
    .head_instr_o (if_instr),
    .head_pc_o    (if_pc)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory responder returns address+0xA000,
// requests push expected {pc} into a scoreboard that deliveries pop.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, fetch_en, br_taken, if_ready;
  logic [63:0] br_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;

  int          checks = 0;
  int          failures = 0;
  int          n_deliv = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_pc;
  logic        hold_q = 1'b0;
  logic [63:0] hold_pc;
  logic [31:0] hold_instr;

  fetch_unit #(.WORD(64), .START_PC(64'h0), .DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_en   (fetch_en),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_ready   (if_ready)
  );

  always #5 clk = ~clk;

  // Instruction memory: answers one cycle after each request
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr[31:0] + 32'hA000) : 32'hBAD0_0BAD;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic [63:0] e;
    if (imem_req) begin
      check("req_addr", imem_addr, exp_pc);
      exp_q.push_back(exp_pc);
      exp_pc = exp_pc + 64'd4;
    end
    if (if_valid && if_ready) begin
      n_deliv++;
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL deliver_extra observed_pc=%h expected=none", if_pc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("if_pc", if_pc, e);
        check("if_instr", {32'h0, if_instr}, {32'h0, e[31:0] + 32'hA000});
      end
    end
    if (hold_q && if_valid) begin
      check("hold_pc", if_pc, hold_pc);
      check("hold_instr", {32'h0, if_instr}, {32'h0, hold_instr});
    end
    hold_q     = if_valid && !if_ready;
    hold_pc    = if_pc;
    hold_instr = if_instr;
    if (br_taken) begin
      exp_q.delete();
      exp_pc = {br_target[63:2], 2'b00};
    end
  endtask

  task automatic tick();
    #1;
    sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; fetch_en = 1'b0; if_ready = 1'b0; br_taken = 1'b0;
    #1;
    exp_q.delete();
    exp_pc = 64'h0;
    hold_q = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; fetch_en = 1'b0; br_taken = 1'b0; br_target = 64'h0; if_ready = 1'b0;
    exp_pc = 64'h0;
    #3;
    check("rst_req", {63'h0, imem_req}, 64'h0);
    check("rst_valid", {63'h0, if_valid}, 64'h0);
    check("rst_addr", imem_addr, 64'h0);
    repeat (2) @(negedge clk);

    // Streaming with first-response latency
    reset = 1'b1; fetch_en = 1'b1; if_ready = 1'b1;
    #1;
    check("a_first_req", {63'h0, imem_req}, 64'h1);
    check("a_valid_c0", {63'h0, if_valid}, 64'h0);
    tick();
    #1 check("a_valid_c1", {63'h0, if_valid}, 64'h0);
    tick();
    #1;
    check("a_valid_c2", {63'h0, if_valid}, 64'h1);
    check("a_pc_c2", if_pc, 64'h0);
    check("a_instr_c2", {32'h0, if_instr}, 64'hA000);
    repeat (8) tick();
    fetch_en = 1'b0;
    repeat (5) tick();
    check("a_drained", 64'(exp_q.size()), 64'h0);
    check("a_valid_end", {63'h0, if_valid}, 64'h0);

    // Backpressure from the start
    do_reset();
    reset = 1'b1; fetch_en = 1'b1; if_ready = 1'b0;
    repeat (3) tick();
    #1;
    check("b_req_stop", {63'h0, imem_req}, 64'h0);
    check("b_addr_hold", imem_addr, 64'h8);
    check("b_head_pc", if_pc, 64'h0);
    tick();
    n_deliv = 0;
    if_ready = 1'b1;
    repeat (8) tick();
    check("b_delivered_some", {63'h0, (n_deliv >= 3)}, 64'h1);
    fetch_en = 1'b0;
    repeat (5) tick();
    check("b_drained", 64'(exp_q.size()), 64'h0);

    // Redirect with a buffered entry and a response in flight
    do_reset();
    reset = 1'b1; fetch_en = 1'b1; if_ready = 1'b0;
    repeat (2) tick();
    br_taken = 1'b1; br_target = 64'h100; if_ready = 1'b1;
    #1 check("c_no_req_br", {63'h0, imem_req}, 64'h0);
    tick();
    br_taken = 1'b0;
    #1;
    check("c_gap1", {63'h0, if_valid}, 64'h0);
    check("c_addr", imem_addr, 64'h100);
    tick();
    #1 check("c_gap2", {63'h0, if_valid}, 64'h0);
    tick();
    #1;
    check("c_valid", {63'h0, if_valid}, 64'h1);
    check("c_pc", if_pc, 64'h100);
    repeat (3) tick();

    // Misaligned redirect target
    br_taken = 1'b1; br_target = 64'h103;
    tick();
    br_taken = 1'b0;
    #1;
    check("d_addr", imem_addr, 64'h100);
    check("d_req", {63'h0, imem_req}, 64'h1);
    repeat (5) tick();

    // Asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    check("e_req", {63'h0, imem_req}, 64'h0);
    check("e_valid", {63'h0, if_valid}, 64'h0);
    check("e_addr", imem_addr, 64'h0);
    exp_q.delete();
    exp_pc = 64'h0;
    hold_q = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("e_first_req", {63'h0, imem_req}, 64'h1);
    check("e_first_addr", imem_addr, 64'h0);
    repeat (6) tick();
    fetch_en = 1'b0;
    repeat (5) tick();
    check("e_drained", 64'(exp_q.size()), 64'h0);

    // fetch_en drop with one buffered and one in flight
    do_reset();
    reset = 1'b1; fetch_en = 1'b1; if_ready = 1'b0;
    repeat (2) tick();
    fetch_en = 1'b0;
    #1 check("f_no_req0", {63'h0, imem_req}, 64'h0);
    tick();
    #1 check("f_no_req1", {63'h0, imem_req}, 64'h0);
    n_deliv = 0;
    if_ready = 1'b1;
    repeat (4) tick();
    check("f_delivered", 64'(n_deliv), 64'h2);
    check("f_drained", 64'(exp_q.size()), 64'h0);
    check("f_valid_end", {63'h0, if_valid}, 64'h0);
    check("f_state_idle", {63'h0, dut.state_q == ST_IDLE}, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
